// File: rtl/hitspy_pkg.sv
// Shared types and helpers for the hit-spy input sequencer.
// Layer maps are carried at the maximum supported width so helpers stay parameter-free.
package hitspy_pkg;

    localparam int unsigned MAX_LAYERS = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_TAIL = 2'd2,
        ST_COPY = 2'd3
    } state_e;

    typedef logic [MAX_LAYERS-1:0] lmap_t;
    typedef logic [3:0]            lidx_t;

    typedef struct packed {
        logic  found;
        lidx_t idx;
    } pick_t;

    function automatic logic [4:0] popcount(input lmap_t v);
        logic [4:0] n;
        n = '0;
        for (int unsigned i = 0; i < MAX_LAYERS; i++) begin
            n = n + {4'b0000, v[i]};
        end
        return n;
    endfunction

    // Lowest set bit at or above 'from'; "next set bit above idx" is next_set_bit(map, idx+1).
    function automatic pick_t next_set_bit(input lmap_t map, input logic [4:0] from);
        pick_t p;
        p = '0;
        for (int unsigned i = 0; i < MAX_LAYERS; i++) begin
            if (!p.found && map[i] && (5'(i) >= from)) begin
                p.found = 1'b1;
                p.idx   = 4'(i);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/hitspy_sequencer_if.sv
// Event input and layer-enable outputs between the hit FIFO, the sequencer and the spy RAM.
interface hitspy_sequencer_if #(
    parameter int unsigned NLAYERS = 5,
    parameter int unsigned EVCNT_W = 16
);
    logic               dv;
    logic [NLAYERS-1:0] hitmap;
    logic [NLAYERS-1:0] ce_layer;
    logic               ce_tail;
    logic               ce_copy;
    logic               ce_copy2;
    logic [NLAYERS-1:0] missing;
    logic               busy;
    logic               reject;
    logic [EVCNT_W-1:0] event_count;

    modport master (
        output dv, hitmap,
        input  ce_layer, ce_tail, ce_copy, ce_copy2, missing, busy, reject, event_count
    );

    modport slave (
        input  dv, hitmap,
        output ce_layer, ce_tail, ce_copy, ce_copy2, missing, busy, reject, event_count
    );
endinterface

// File: rtl/hitspy_hmap_delay.sv
// WIDTH x DEPTH shift register aligning the hitmap with the hit data stream.
module hitspy_hmap_delay #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe_q [DEPTH];
    logic [WIDTH-1:0] pipe_d [DEPTH];

    always_comb begin
        pipe_d[0] = din;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/hitspy_sequencer.sv
// Hit-spy input sequencer: per event, one-hot layer write enables, then tail and copy strobes.
// Supports skip/fixed-slot visiting, missing-layer rejection and back-to-back events.
module hitspy_sequencer
    import hitspy_pkg::*;
#(
    parameter int unsigned NLAYERS     = 5,
    parameter int unsigned HMAP_DELAY  = 2,
    parameter int unsigned MAX_MISS    = 1,
    parameter int unsigned SKIP_MODE   = 1,
    parameter int unsigned COPY2_DELAY = 6,
    parameter int unsigned EVCNT_W     = 16
) (
    input  logic               clock,
    input  logic               reset,
    hitspy_sequencer_if.slave  bus
);

    localparam int unsigned C2_W = $clog2(COPY2_DELAY + 2);

    state_e             state_q, state_d;
    lidx_t              idx_q, idx_d;
    logic [NLAYERS-1:0] ev_map_q, ev_map_d;
    logic [NLAYERS-1:0] missing_q, missing_d;
    logic [EVCNT_W-1:0] evcnt_q, evcnt_d;
    logic [C2_W-1:0]    count2_q, count2_d;

    logic [NLAYERS-1:0] hmap_dly;
    lmap_t              hmap_ext, miss_ext, ev_ext;
    logic [4:0]         nmiss;
    logic [4:0]         idx_from;
    pick_t              first_pick, next_pick;
    logic               start;
    logic               reject;
    logic               ce_tail;
    logic               ce_copy;

    hitspy_hmap_delay #(
        .WIDTH (NLAYERS),
        .DEPTH (HMAP_DELAY)
    ) u_hmap_delay (
        .clock (clock),
        .reset (reset),
        .din   (bus.hitmap),
        .dout  (hmap_dly)
    );

    always_comb begin
        hmap_ext                = '0;
        miss_ext                = '0;
        ev_ext                  = '0;
        hmap_ext[NLAYERS-1:0]   = hmap_dly;
        miss_ext[NLAYERS-1:0]   = ~hmap_dly;
        ev_ext[NLAYERS-1:0]     = ev_map_q;
        nmiss                   = popcount(miss_ext);
        idx_from                = {1'b0, idx_q} + 5'd1;
        if (SKIP_MODE != 0) begin
            first_pick = next_set_bit(hmap_ext, 5'd0);
            next_pick  = next_set_bit(ev_ext, idx_from);
        end else begin
            first_pick = '{found: 1'b1, idx: '0};
            next_pick  = '{found: (idx_from < 5'(NLAYERS)), idx: idx_from[3:0]};
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ev_map_d  = ev_map_q;
        missing_d = missing_q;
        evcnt_d   = evcnt_q;
        start     = 1'b0;
        reject    = 1'b0;
        ce_tail   = 1'b0;
        ce_copy   = 1'b0;

        case (state_q)
            ST_IDLE: start = bus.dv;
            ST_SCAN: begin
                if (next_pick.found) begin
                    idx_d = next_pick.idx;
                end else begin
                    state_d = ST_TAIL;
                end
            end
            ST_TAIL: begin
                ce_tail = 1'b1;
                state_d = ST_COPY;
            end
            ST_COPY: begin
                ce_copy = 1'b1;
                evcnt_d = evcnt_q + EVCNT_W'(1);
                state_d = ST_IDLE;
                start   = bus.dv;
            end
            default: state_d = ST_IDLE;
        endcase

        // A start in COPY overrides the return to IDLE, giving back-to-back events.
        if (start) begin
            if (32'(nmiss) > MAX_MISS) begin
                reject  = 1'b1;
                state_d = ST_IDLE;
            end else begin
                ev_map_d  = hmap_dly;
                missing_d = ~hmap_dly;
                if (first_pick.found) begin
                    state_d = ST_SCAN;
                    idx_d   = first_pick.idx;
                end else begin
                    state_d = ST_TAIL;
                end
            end
        end
    end

    always_comb begin
        if (state_q == ST_COPY) begin
            count2_d = C2_W'(1);
        end else if (count2_q != C2_W'(COPY2_DELAY + 1)) begin
            count2_d = count2_q + C2_W'(1);
        end else begin
            count2_d = count2_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            ev_map_q  <= '0;
            missing_q <= '0;
            evcnt_q   <= '0;
            count2_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ev_map_q  <= ev_map_d;
            missing_q <= missing_d;
            evcnt_q   <= evcnt_d;
            count2_q  <= count2_d;
        end
    end

    assign bus.ce_layer    = (state_q == ST_SCAN) ? (NLAYERS'(1) << idx_q) : '0;
    assign bus.ce_tail     = ce_tail;
    assign bus.ce_copy     = ce_copy;
    assign bus.ce_copy2    = (count2_q == C2_W'(COPY2_DELAY));
    assign bus.missing     = missing_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.reject      = reject;
    assign bus.event_count = evcnt_q;

endmodule

// File: tb/tb_hitspy_sequencer.sv
// Bench for hitspy_sequencer: a skip-mode and a fixed-slot instance share one stimulus stream.
// Expected values come from a directed table, hand sequences and an event-queue reference model.
module tb_hitspy_sequencer;

    localparam int NL     = 5;
    localparam int HD     = 2;
    localparam int MM     = 1;
    localparam int C2     = 6;
    localparam int TAIL_T = 100;
    localparam int COPY_T = 101;
    localparam int NROWS  = 23;

    logic       clock;
    logic       reset;
    logic       dv;
    logic [4:0] hitmap;

    hitspy_sequencer_if #(.NLAYERS(NL), .EVCNT_W(16)) a_if ();
    hitspy_sequencer_if #(.NLAYERS(NL), .EVCNT_W(16)) b_if ();

    assign a_if.dv     = dv;
    assign a_if.hitmap = hitmap;
    assign b_if.dv     = dv;
    assign b_if.hitmap = hitmap;

    hitspy_sequencer #(
        .NLAYERS(NL), .HMAP_DELAY(HD), .MAX_MISS(MM), .SKIP_MODE(1), .COPY2_DELAY(C2), .EVCNT_W(16)
    ) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (a_if.slave)
    );

    hitspy_sequencer #(
        .NLAYERS(NL), .HMAP_DELAY(HD), .MAX_MISS(MM), .SKIP_MODE(0), .COPY2_DELAY(C2), .EVCNT_W(16)
    ) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (b_if.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        dv;
        logic [4:0]  hm;
        logic [4:0]  lay;
        logic        tail;
        logic        copy;
        logic        copy2;
        logic        busy;
        logic        rej;
        logic [4:0]  miss;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [NROWS];

    int checks = 0;
    int errors = 0;

    // Reference model: hitmap history plus, per instance, a queue of upcoming strobes.
    logic [4:0] hist [HD];
    int         plan0 [$];
    int         plan1 [$];
    logic [4:0] m_miss [2];
    int         m_cnt  [2];
    int         m_c2   [2];
    logic       m_start [2];
    logic       m_rej   [2];

    logic [4:0]  s_lay  [2];
    logic        s_tail [2];
    logic        s_copy [2];
    logic        s_c2   [2];
    logic        s_busy [2];
    logic        s_rej  [2];
    logic [4:0]  s_miss [2];
    logic [15:0] s_cnt  [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sample();
        s_lay[0] = a_if.ce_layer; s_tail[0] = a_if.ce_tail; s_copy[0] = a_if.ce_copy;
        s_c2[0]  = a_if.ce_copy2; s_busy[0] = a_if.busy;   s_rej[0]  = a_if.reject;
        s_miss[0] = a_if.missing; s_cnt[0]  = a_if.event_count;
        s_lay[1] = b_if.ce_layer; s_tail[1] = b_if.ce_tail; s_copy[1] = b_if.ce_copy;
        s_c2[1]  = b_if.ce_copy2; s_busy[1] = b_if.busy;   s_rej[1]  = b_if.reject;
        s_miss[1] = b_if.missing; s_cnt[1]  = b_if.event_count;
    endtask

    task automatic model_reset();
        plan0.delete();
        plan1.delete();
        for (int k = 0; k < HD; k++) hist[k] = '0;
        for (int u = 0; u < 2; u++) begin
            m_miss[u] = '0; m_cnt[u] = 0; m_c2[u] = 0; m_start[u] = 1'b0; m_rej[u] = 1'b0;
        end
    endtask

    task automatic model_check(input int u);
        int         q [$];
        int         head;
        int         nm;
        logic       bsy;
        logic [4:0] hd;
        logic [4:0] exp_lay;
        string      nm_u;
        if (u == 0) q = plan0; else q = plan1;
        nm_u = (u == 0) ? "skip" : "fixed";
        hd   = hist[HD-1];
        bsy  = (q.size() != 0);
        head = bsy ? q[0] : -1;
        exp_lay = (head >= 0 && head < NL) ? 5'(1 << head) : 5'd0;
        nm = 0;
        for (int l = 0; l < NL; l++) if (!hd[l]) nm++;
        m_start[u] = dv && (!bsy || head == COPY_T);
        m_rej[u]   = m_start[u] && (nm > MM);
        chk({nm_u, ".ce_layer"}, 32'(s_lay[u]), 32'(exp_lay));
        chk({nm_u, ".ce_tail"},  32'(s_tail[u]), 32'(head == TAIL_T));
        chk({nm_u, ".ce_copy"},  32'(s_copy[u]), 32'(head == COPY_T));
        chk({nm_u, ".ce_copy2"}, 32'(s_c2[u]), 32'(m_c2[u] == C2));
        chk({nm_u, ".busy"},     32'(s_busy[u]), 32'(bsy));
        chk({nm_u, ".reject"},   32'(s_rej[u]), 32'(m_rej[u]));
        chk({nm_u, ".missing"},  32'(s_miss[u]), 32'(m_miss[u]));
        chk({nm_u, ".event_count"}, 32'(s_cnt[u]), 32'(m_cnt[u]));
    endtask

    task automatic model_update(input int u);
        int         q [$];
        int         item;
        logic [4:0] hd;
        if (u == 0) q = plan0; else q = plan1;
        hd   = hist[HD-1];
        item = (q.size() != 0) ? q.pop_front() : -1;
        if (item == COPY_T) begin
            m_cnt[u] = (m_cnt[u] + 1) % 65536;
            m_c2[u]  = 1;
        end else if (m_c2[u] < C2 + 1) begin
            m_c2[u]++;
        end
        if (m_start[u] && !m_rej[u]) begin
            m_miss[u] = ~hd;
            for (int l = 0; l < NL; l++) if (u == 1 || hd[l]) q.push_back(l);
            q.push_back(TAIL_T);
            q.push_back(COPY_T);
        end
        if (u == 0) plan0 = q; else plan1 = q;
    endtask

    task automatic cyc(input logic d, input logic [4:0] h, input int row);
        @(negedge clock);
        dv = d;
        hitmap = h;
        #1;
        sample();
        model_check(0);
        model_check(1);
        if (row >= 0) begin
            chk($sformatf("tbl%0d.ce_layer", row), 32'(s_lay[0]), 32'(tbl[row].lay));
            chk($sformatf("tbl%0d.ce_tail", row),  32'(s_tail[0]), 32'(tbl[row].tail));
            chk($sformatf("tbl%0d.ce_copy", row),  32'(s_copy[0]), 32'(tbl[row].copy));
            chk($sformatf("tbl%0d.ce_copy2", row), 32'(s_c2[0]), 32'(tbl[row].copy2));
            chk($sformatf("tbl%0d.busy", row),     32'(s_busy[0]), 32'(tbl[row].busy));
            chk($sformatf("tbl%0d.reject", row),   32'(s_rej[0]), 32'(tbl[row].rej));
            chk($sformatf("tbl%0d.missing", row),  32'(s_miss[0]), 32'(tbl[row].miss));
            chk($sformatf("tbl%0d.event_count", row), 32'(s_cnt[0]), 32'(tbl[row].cnt));
        end
        @(posedge clock);
        model_update(0);
        model_update(1);
        for (int k = HD - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = h;
    endtask

    task automatic set_row(input int i, input logic d, input logic [4:0] hm, input logic [4:0] lay,
                           input logic tl, input logic cp, input logic c2, input logic bsy,
                           input logic rj, input logic [4:0] ms, input logic [15:0] cnt);
        tbl[i] = '{d, hm, lay, tl, cp, c2, bsy, rj, ms, cnt};
    endtask

    task automatic reset_mid();
        #2;
        reset = 1'b0;
        dv = 1'b0;
        #1;
        sample();
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("rst%0d.ce_layer", u), 32'(s_lay[u]), 32'd0);
            chk($sformatf("rst%0d.ce_tail", u),  32'(s_tail[u]), 32'd0);
            chk($sformatf("rst%0d.ce_copy", u),  32'(s_copy[u]), 32'd0);
            chk($sformatf("rst%0d.ce_copy2", u), 32'(s_c2[u]), 32'd0);
            chk($sformatf("rst%0d.busy", u),     32'(s_busy[u]), 32'd0);
            chk($sformatf("rst%0d.missing", u),  32'(s_miss[u]), 32'd0);
            chk($sformatf("rst%0d.event_count", u), 32'(s_cnt[u]), 32'd0);
        end
        model_reset();
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        int         copies;
        logic       prev_copy;
        logic [4:0] h;
        int         a, b;

        // Directed full event, skip event and reject, starting with count2 saturated.
        set_row( 0, 1, 5'b11111, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 0);
        set_row( 1, 0, 5'b11111, 5'b00001, 0, 0, 0, 1, 0, 5'b00000, 0);
        set_row( 2, 0, 5'b11111, 5'b00010, 0, 0, 0, 1, 0, 5'b00000, 0);
        set_row( 3, 0, 5'b11111, 5'b00100, 0, 0, 0, 1, 0, 5'b00000, 0);
        set_row( 4, 0, 5'b11111, 5'b01000, 0, 0, 0, 1, 0, 5'b00000, 0);
        set_row( 5, 0, 5'b11111, 5'b10000, 0, 0, 0, 1, 0, 5'b00000, 0);
        set_row( 6, 0, 5'b11111, 5'b00000, 1, 0, 0, 1, 0, 5'b00000, 0);
        set_row( 7, 0, 5'b11111, 5'b00000, 0, 1, 0, 1, 0, 5'b00000, 0);
        set_row( 8, 0, 5'b11111, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 1);
        set_row( 9, 0, 5'b11111, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 1);
        set_row(10, 0, 5'b11111, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 1);
        set_row(11, 0, 5'b11111, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 1);
        set_row(12, 0, 5'b11011, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 1);
        set_row(13, 0, 5'b11011, 5'b00000, 0, 0, 1, 0, 0, 5'b00000, 1);
        set_row(14, 1, 5'b11011, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 1);
        set_row(15, 0, 5'b11011, 5'b00001, 0, 0, 0, 1, 0, 5'b00100, 1);
        set_row(16, 0, 5'b11011, 5'b00010, 0, 0, 0, 1, 0, 5'b00100, 1);
        set_row(17, 0, 5'b11011, 5'b01000, 0, 0, 0, 1, 0, 5'b00100, 1);
        set_row(18, 0, 5'b11011, 5'b10000, 0, 0, 0, 1, 0, 5'b00100, 1);
        set_row(19, 0, 5'b10011, 5'b00000, 1, 0, 0, 1, 0, 5'b00100, 1);
        set_row(20, 0, 5'b10011, 5'b00000, 0, 1, 0, 1, 0, 5'b00100, 1);
        set_row(21, 1, 5'b10011, 5'b00000, 0, 0, 0, 0, 1, 5'b00100, 2);
        set_row(22, 0, 5'b10011, 5'b00000, 0, 0, 0, 0, 0, 5'b00100, 2);

        reset = 1'b0;
        dv = 1'b0;
        hitmap = '0;
        model_reset();
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;

        repeat (8) cyc(1'b0, 5'b11111, -1);
        for (int i = 0; i < NROWS; i++) cyc(tbl[i].dv, tbl[i].hm, i);
        repeat (4) cyc(1'b0, 5'b01111, -1);

        // Fixed-slot instance must fill all five slots despite the missing layer 4.
        cyc(1'b1, 5'b01111, -1);
        for (int i = 0; i < NL; i++) begin
            cyc(1'b0, 5'b01111, -1);
            chk($sformatf("fixed_slot%0d", i), 32'(s_lay[1]), 32'(1) << i);
        end
        chk("fixed_missing", 32'(s_miss[1]), 32'h10);
        chk("skip_tail_after_4", 32'(s_tail[0]), 32'd1);
        repeat (4) cyc(1'b0, 5'b11111, -1);

        // Back-to-back: dv held high over two events.
        copies = 0;
        prev_copy = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cyc(i < 14, 5'b11111, -1);
            if (prev_copy) begin
                chk("b2b_first_layer", 32'(s_lay[0]), 32'd1);
                chk("b2b_busy", 32'(s_busy[0]), 32'd1);
            end
            prev_copy = s_copy[0];
            if (s_copy[0]) copies++;
        end
        chk("b2b_copies", 32'(copies), 32'd2);
        repeat (8) cyc(1'b0, 5'b11111, -1);

        // Asynchronous reset in the middle of a scan.
        cyc(1'b1, 5'b11111, -1);
        cyc(1'b0, 5'b11111, -1);
        cyc(1'b0, 5'b11111, -1);
        reset_mid();
        cyc(1'b0, 5'b11111, -1);
        cyc(1'b0, 5'b11111, -1);
        cyc(1'b1, 5'b11111, -1);
        cyc(1'b0, 5'b11111, -1);
        chk("post_reset_first_layer", 32'(s_lay[0]), 32'd1);
        repeat (8) cyc(1'b0, 5'b11111, -1);

        // Random traffic biased towards acceptable events.
        for (int i = 0; i < 400; i++) begin
            a = int'($urandom_range(0, NL - 1));
            b = int'($urandom_range(0, NL - 1));
            case ($urandom_range(0, 3))
                0:       h = 5'b11111;
                1:       h = ~(5'(1 << a));
                2:       h = ~(5'(1 << a) | 5'(1 << b));
                default: h = 5'($urandom);
            endcase
            cyc($urandom_range(0, 2) == 0, h, -1);
        end
        repeat (12) cyc(1'b0, 5'b11111, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hitspy_sequencer.md
Name: hitspy_sequencer

Overview:
- Parametrised successor of the hit-spy input control.
- Delays the per-layer hitmap to align with hit data.
- On each data-valid event, sequences one-hot write enables over NLAYERS layer registers, then a tail and a copy strobe.
- Adds a selectable skip/fixed-slot mode, missing-layer rejection, back-to-back events and an event counter.
- Sits between the hit input FIFO and the hit-spy buffer RAM.

Parameters:
- NLAYERS, 5: number of detector layers (2..16).
- HMAP_DELAY, 2: hitmap alignment delay in cycles (1..8).
- MAX_MISS, 1: maximum missing layers accepted; events with more are rejected.
- SKIP_MODE, 1: 1 = visit only layers with hits; 0 = visit every layer.
- COPY2_DELAY, 6: cycles after a copy at which ce_copy2 fires.
- EVCNT_W, 16: width of the event counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- dv  in  1  event data valid.
- hitmap  in  NLAYERS  bit i = 1 means layer i has a hit.
- ce_layer  out  NLAYERS  one-hot layer register write enable.
- ce_tail  out  1  tail register write enable.
- ce_copy  out  1  copy strobe; event complete.
- ce_copy2  out  1  delayed copy strobe.
- missing  out  NLAYERS  missing-hit flags for the current event.
- busy  out  1  sequence in progress.
- reject  out  1  one-cycle pulse; event rejected for too many misses.
- event_count  out  EVCNT_W  count of completed events.

Behaviour:
- Reset (async, reset=0):
  - FSM goes to IDLE.
  - Delay pipeline, missing, count2 and event_count clear to 0.
  - All strobes are 0.
  - Release is synchronous to the next clock edge.
- Delay pipeline:
  - hmap_d is hitmap delayed by exactly HMAP_DELAY registers.
  - The FSM uses only hmap_d.
- States: IDLE, SCAN, TAIL, COPY.
- Start condition (evaluated in IDLE, or in COPY when dv=1):
  - nmiss = popcount(~hmap_d).
  - If nmiss > MAX_MISS:
    - reject=1 for that cycle and next state is IDLE.
    - missing, event_count and all ce_* are unchanged.
  - Otherwise:
    - Latch ev_map = hmap_d and missing <= ~hmap_d.
    - Next state is SCAN, with idx = first layer to visit.
    - SKIP_MODE=1: first layer is the lowest set bit of ev_map. SKIP_MODE=0: first layer is layer 0.
    - If SKIP_MODE=1 and ev_map=0, go directly to TAIL.
- SCAN:
  - ce_layer[idx]=1.
  - idx advances to the next visited layer in ascending order.
  - After the last visited layer, next state is TAIL.
- TAIL: ce_tail=1 for one cycle, then COPY.
- COPY:
  - ce_copy=1 for one cycle and event_count increments, wrapping modulo 2^EVCNT_W.
  - If dv=1, the start condition applies in the same cycle (back-to-back, no IDLE gap). Otherwise next state is IDLE.
- busy = (state != IDLE).
- dv is ignored in SCAN and TAIL.
- Latency:
  - dv at edge t (IDLE) gives the first ce_layer at t+1.
  - k visited layers give ce_tail at t+1+k and ce_copy at t+2+k.
- ce_copy2 counter (count2):
  - count2 loads 1 on a COPY cycle.
  - Otherwise it increments, saturating at COPY2_DELAY+1.
  - ce_copy2 = (count2 == COPY2_DELAY), combinational.
- missing holds its value until the next accepted event.
- At most one ce_layer bit is high in any cycle; ce_layer, ce_tail and ce_copy are mutually exclusive.
- Reset asserted mid-sequence aborts the event: no ce_copy is issued and event_count is not incremented.

Decomposition:
- Shared package hitspy_pkg holds:
  - the state encoding (IDLE=0, SCAN=1, TAIL=2, COPY=3);
  - a popcount function;
  - a priority-encoder function "next set bit above idx".
- One sub-module, hitspy_hmap_delay: a parametrised NLAYERS x HMAP_DELAY shift register with async active-low clear.

Test Plan (defaults unless noted):
- Full event: hitmap=5'b11111, dv pulsed one cycle after the delay aligns.
  - ce_layer = 00001, 00010, 00100, 01000, 10000 on consecutive cycles, then ce_tail, then ce_copy.
  - missing=0, event_count=1.
  - ce_copy2 exactly 6 cycles after ce_copy.
- Skip mode, hitmap=5'b11011:
  - ce_layer visits layers 0, 1, 3, 4 (4 cycles), then tail and copy.
  - missing=5'b00100.
- Reject: hitmap=5'b10011 (2 misses > MAX_MISS=1):
  - reject pulses once, no ce_* asserted, busy stays 0, event_count unchanged.
- Fixed-slot mode, SKIP_MODE=0, hitmap=5'b01111:
  - all 5 ce_layer slots asserted.
  - missing=5'b10000.
- Back-to-back: dv held high across two events.
  - The second event's first ce_layer immediately follows ce_copy, with no IDLE cycle.
  - event_count goes 1 then 2.
- Async reset: assert reset=0 mid-SCAN (between clock edges).
  - All outputs go to 0 immediately and busy=0.
  - After release, a new dv event sequences normally from layer 0.
